// File: rtl/wordle_pkg.sv
// Shared tile/row layout, board defaults and entry FSM encoding for the word-guess game.
package wordle_pkg;

  localparam int TILE_W       = 7;
  localparam int YELLOW_BIT   = 6;
  localparam int GREEN_BIT    = 5;
  localparam int LETTER_W     = 5;
  localparam int WORD_LEN_DEF = 5;
  localparam int MAX_ROWS_DEF = 6;
  localparam int ROW_W        = TILE_W * WORD_LEN_DEF;

  localparam logic [LETTER_W-1:0] LETTER_BLANK = 5'd0;

  typedef enum logic [0:0] {
    ST_TYPING = 1'b0,
    ST_DONE   = 1'b1
  } entry_state_t;

  // A row wins only when every tile carries the green flag.
  function automatic logic all_green(input logic [ROW_W-1:0] row);
    logic g;
    g = 1'b1;
    for (int i = 0; i < WORD_LEN_DEF; i++) begin
      g = g & row[i*TILE_W + GREEN_BIT];
    end
    return g;
  endfunction

endpackage

// File: rtl/guess_entry.sv
// Keystroke-driven guess builder and six-row board recorder with win/loss detection.
// Backspace editing is built only when GUESS_BACKSPACE_EN is defined.
module guess_entry
  import wordle_pkg::*;
#(
  parameter int MAX_ROWS = MAX_ROWS_DEF,
  parameter int WORD_LEN = WORD_LEN_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      key_valid,
  input  logic [4:0]                key_code,
  input  logic                      key_enter,
  input  logic                      key_back,
  input  logic                      new_game,
  output logic [34:0]               cur_row,
  input  logic [34:0]               scored_row,
  output logic [35*MAX_ROWS-1:0]    board,
  output logic [2:0]                row_idx,
  output logic [2:0]                cursor,
  output logic                      won,
  output logic                      lost,
  output logic                      commit
);

  entry_state_t           r_state;
  logic [34:0]            r_cur_row;
  logic [35*MAX_ROWS-1:0] r_board;
  logic [2:0]             r_row_idx;
  logic [2:0]             r_cursor;
  logic                   r_won;
  logic                   r_lost;
  logic                   r_commit;

  logic w_win;
  logic w_row_full;
  logic w_letter_ok;
  logic w_unused_back;

  assign w_win         = all_green(scored_row);
  assign w_row_full    = (r_cursor == 3'(WORD_LEN));
  assign w_letter_ok   = (key_code != LETTER_BLANK) && (r_cursor < 3'(WORD_LEN));
  assign w_unused_back = key_back;

  // Entry FSM: edits the typed row, commits scored rows and latches the game result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_TYPING;
      r_cur_row <= 35'd0;
      r_board   <= '0;
      r_row_idx <= 3'd0;
      r_cursor  <= 3'd0;
      r_won     <= 1'b0;
      r_lost    <= 1'b0;
      r_commit  <= 1'b0;
    end else begin
      r_commit <= 1'b0;
      if (new_game) begin
        r_state   <= ST_TYPING;
        r_cur_row <= 35'd0;
        r_board   <= '0;
        r_row_idx <= 3'd0;
        r_cursor  <= 3'd0;
        r_won     <= 1'b0;
        r_lost    <= 1'b0;
      end else begin
        case (r_state)
          ST_TYPING: begin
            if (key_valid) begin
              if (key_enter) begin
                if (w_row_full) begin
                  for (int r = 0; r < MAX_ROWS; r++) begin
                    if (r_row_idx == 3'(r)) begin
                      r_board[r*35 +: 35] <= scored_row;
                    end
                  end
                  r_commit  <= 1'b1;
                  r_cur_row <= 35'd0;
                  r_cursor  <= 3'd0;
                  r_row_idx <= r_row_idx + 3'd1;
                  if (w_win) begin
                    r_won   <= 1'b1;
                    r_state <= ST_DONE;
                  end else if (r_row_idx == 3'(MAX_ROWS - 1)) begin
                    r_lost  <= 1'b1;
                    r_state <= ST_DONE;
                  end
                end
              end
`ifdef GUESS_BACKSPACE_EN
              else if (key_back) begin
                if (r_cursor != 3'd0) begin
                  r_cursor <= r_cursor - 3'd1;
                  // The tile being cleared is the one most recently filled.
                  for (int t = 0; t < WORD_LEN; t++) begin
                    if (r_cursor == 3'(WORD_LEN - t)) begin
                      r_cur_row[t*TILE_W +: TILE_W] <= 7'd0;
                    end
                  end
                end
              end
`endif
              else if (w_letter_ok) begin
                for (int t = 0; t < WORD_LEN; t++) begin
                  if (r_cursor == 3'(WORD_LEN - 1 - t)) begin
                    r_cur_row[t*TILE_W +: TILE_W] <= {2'b00, key_code};
                  end
                end
                r_cursor <= r_cursor + 3'd1;
              end
            end
          end
          ST_DONE: begin
            r_state <= ST_DONE;
          end
          default: begin
            r_state <= ST_TYPING;
          end
        endcase
      end
    end
  end

  assign cur_row = r_cur_row;
  assign board   = r_board;
  assign row_idx = r_row_idx;
  assign cursor  = r_cursor;
  assign won     = r_won;
  assign lost    = r_lost;
  assign commit  = r_commit;

endmodule

// File: tb/tb_guess_entry.sv
// Directed scoreboard bench for guess_entry: a behavioural game model queues expected outputs per step.
module tb_guess_entry;

  localparam int MR = 6;
`ifdef GUESS_BACKSPACE_EN
  localparam bit BS_EN = 1'b1;
`else
  localparam bit BS_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            key_valid;
  logic [4:0]      key_code;
  logic            key_enter;
  logic            key_back;
  logic            new_game;
  logic [34:0]     cur_row;
  logic [34:0]     scored_row;
  logic [35*MR-1:0] board;
  logic [2:0]      row_idx;
  logic [2:0]      cursor;
  logic            won;
  logic            lost;
  logic            commit;

  always #5 clk = ~clk;

  guess_entry #(.MAX_ROWS(MR), .WORD_LEN(5)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .key_enter(key_enter), .key_back(key_back), .new_game(new_game),
    .cur_row(cur_row), .scored_row(scored_row), .board(board),
    .row_idx(row_idx), .cursor(cursor), .won(won), .lost(lost), .commit(commit)
  );

  typedef struct {
    logic [34:0]      cur_row;
    logic [2:0]       cursor;
    logic [2:0]       row_idx;
    logic [35*MR-1:0] board;
    logic             won;
    logic             lost;
    logic             commit;
  } exp_t;

  exp_t exp_q[$];

  logic [34:0]      m_cur;
  logic [2:0]       m_cursor;
  logic [2:0]       m_row;
  logic [35*MR-1:0] m_board;
  logic             m_won, m_lost, m_commit, m_done;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_cur = '0; m_cursor = '0; m_row = '0; m_board = '0;
    m_won = 1'b0; m_lost = 1'b0; m_commit = 1'b0; m_done = 1'b0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.cur_row = m_cur; e.cursor = m_cursor; e.row_idx = m_row; e.board = m_board;
    e.won = m_won; e.lost = m_lost; e.commit = m_commit;
    exp_q.push_back(e);
  endtask

  task automatic compare_all(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty, observed none expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, ".cur_row"}, 256'(cur_row), 256'(e.cur_row));
      chk({tag, ".cursor"},  256'(cursor),  256'(e.cursor));
      chk({tag, ".row_idx"}, 256'(row_idx), 256'(e.row_idx));
      chk({tag, ".board"},   256'(board),   256'(e.board));
      chk({tag, ".won"},     256'(won),     256'(e.won));
      chk({tag, ".lost"},    256'(lost),    256'(e.lost));
      chk({tag, ".commit"},  256'(commit),  256'(e.commit));
    end
  endtask

  // Game model: one call per clock, mirroring what the block should do to its outputs.
  task automatic model_step(input logic kv, input logic ent, input logic bk, input logic ng,
                            input logic [4:0] code, input logic [34:0] sc);
    int t;
    logic win;
    m_commit = 1'b0;
    if (ng) begin
      model_clear();
    end else if (kv && !m_done) begin
      if (ent) begin
        if (m_cursor == 3'd5) begin
          m_board[m_row*35 +: 35] = sc;
          m_commit = 1'b1;
          m_cur = '0;
          m_cursor = 3'd0;
          win = sc[33] & sc[26] & sc[19] & sc[12] & sc[5];
          if (win) begin
            m_won = 1'b1; m_done = 1'b1;
          end else if (m_row == 3'd5) begin
            m_lost = 1'b1; m_done = 1'b1;
          end
          m_row = m_row + 3'd1;
        end
      end else if (bk && BS_EN) begin
        if (m_cursor > 3'd0) begin
          m_cursor = m_cursor - 3'd1;
          t = 4 - int'(m_cursor);
          m_cur[t*7 +: 7] = 7'd0;
        end
      end else if (code != 5'd0 && m_cursor < 3'd5) begin
        t = 4 - int'(m_cursor);
        m_cur[t*7 +: 7] = {2'b00, code};
        m_cursor = m_cursor + 3'd1;
      end
    end
  endtask

  // Called at posedge+1: drive, predict, clock, then compare.
  task automatic step(input logic kv, input logic ent, input logic bk, input logic ng,
                      input logic [4:0] code, input logic [34:0] sc, input string tag);
    key_valid = kv; key_enter = ent; key_back = bk; new_game = ng;
    key_code = code; scored_row = sc;
    model_step(kv, ent, bk, ng, code, sc);
    push_exp();
    @(posedge clk);
    #1;
    key_valid = 1'b0; key_enter = 1'b0; key_back = 1'b0; new_game = 1'b0;
    key_code = 5'd0; scored_row = 35'd0;
    compare_all(tag);
  endtask

  task automatic letter(input logic [4:0] code, input string tag);
    step(1'b1, 1'b0, 1'b0, 1'b0, code, 35'd0, tag);
  endtask

  function automatic logic [34:0] win_row(input logic [24:0] letters);
    logic [34:0] r;
    for (int i = 0; i < 5; i++) r[i*7 +: 7] = {2'b01, letters[i*5 +: 5]};
    return r;
  endfunction

  function automatic logic [34:0] lose_row(input int seed);
    logic [34:0] r;
    r = {3'($urandom_range(7, 0)), 32'($urandom)} ^ 35'(seed);
    r[5] = 1'b0;
    return r;
  endfunction

  logic [4:0] crane [5];

  initial begin
    crane[0] = 5'd3; crane[1] = 5'd18; crane[2] = 5'd1; crane[3] = 5'd14; crane[4] = 5'd5;
    rst_n = 1'b0; key_valid = 1'b0; key_code = 5'd0; key_enter = 1'b0;
    key_back = 1'b0; new_game = 1'b0; scored_row = 35'd0;
    model_clear();
    #2;
    push_exp();
    compare_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) letter(crane[i], "type");
    chk("crane_first", 256'(cur_row[32:28]), 256'(5'd3));
    chk("crane_last",  256'(cur_row[4:0]),   256'(5'd5));
    letter(5'd7, "sixth_letter");
    letter(5'd0, "code0_full");

    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 35'd0, "ng1");
    letter(5'd3, "bs_c");
    letter(5'd18, "bs_r");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 35'd0, "backspace");
    letter(5'd0, "code0_noop");

    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 35'd0, "ng2");
    for (int i = 0; i < 4; i++) letter(crane[i], "short_type");
    step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, lose_row(1), "short_enter");
    letter(5'd5, "fill5");
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'd9, win_row({5'd5, 5'd14, 5'd1, 5'd18, 5'd3}), "win_enter");
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 35'd0, "win_idle");
    letter(5'd4, "done_letter");
    step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, win_row(25'h0), "done_enter");

    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 35'd0, "ng3");
    for (int g = 0; g < MR; g++) begin
      for (int i = 0; i < 5; i++) letter(5'(g + i + 1), "loss_type");
      step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, lose_row(g), "loss_enter");
    end
    letter(5'd2, "lost_letter");

    step(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 35'd0, "ng4");
    letter(5'd20, "pre_rst_a");
    letter(5'd21, "pre_rst_b");
    #3;
    rst_n = 1'b0;
    #1;
    model_clear();
    push_exp();
    compare_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) letter(crane[i], "ng_type");
    step(1'b1, 1'b1, 1'b0, 1'b1, 5'd0, win_row(25'h1), "ng_with_enter");
    letter(5'd8, "after_ng");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/guess_entry.md
# guess_entry

Builds the player's current guess one keystroke at a time and presents it as a 35-bit tile row to the combinational colour scorer. It captures the scored row into a six-row board on submit, advances the guess counter, and detects win or loss. It sits between the debounced keyboard decoder (upstream) and the colour scorer plus VGA board renderer (downstream).

## Interface

Parameters:
- `MAX_ROWS`, default 6: number of guesses allowed.
- `WORD_LEN`, default 5: letters per guess. Fixed by the row format; not intended to change.

Ports:
- `clk` input, 1: system clock.
- `rst_n` input, 1: reset. Asynchronous, active-low.
- `key_valid` input, 1: one-cycle strobe; a key event is present.
- `key_code` input, 5: letter code 1..26 = A..Z. Code 0 is ignored.
- `key_enter` input, 1: qualifies `key_valid` as Enter.
- `key_back` input, 1: qualifies `key_valid` as Backspace.
- `new_game` input, 1: one-cycle strobe; clears the board and the state.
- `cur_row` output, 35: row being typed, driven to the scorer. Per tile: {yellow, green, letter[4:0]}. Tile 4 occupies [34:28] and is the first letter typed. Colour bits are always 0.
- `scored_row` input, 35: scorer output for `cur_row`, sampled on the same cycle.
- `board` output, 35*MAX_ROWS: committed rows. Row 0 occupies [34:0].
- `row_idx` output, 3: index of the row being typed, 0..MAX_ROWS.
- `cursor` output, 3: number of letters typed, 0..5.
- `won` output, 1: sticky; the game ended with all tiles green.
- `lost` output, 1: sticky; MAX_ROWS guesses made without a win.
- `commit` output, 1: one-cycle pulse on the cycle a row is written into `board`.

## Operation

- State machine with states TYPING, DONE.
- Reset or `new_game` clears every output to 0 (`board`, `cur_row`, `row_idx`, `cursor`, `won`, `lost`, `commit`) and enters TYPING. `new_game` takes priority over any key in the same cycle.
- In TYPING, when `key_valid` is high:
  - Enter has priority over Backspace, which has priority over a letter.
  - **Letter:** if `cursor` < 5 and `key_code` != 0, write the code into tile (4 − `cursor`) and increment `cursor`. When `cursor` == 5 the letter is dropped.
  - **Backspace:** if `cursor` > 0, decrement `cursor` and zero that tile. When `cursor` == 0 it is a no-op.
  - **Enter:** ignored unless `cursor` == 5. When `cursor` == 5:
    - write `scored_row` into `board[row_idx]` and pulse `commit`;
    - clear `cur_row` and `cursor`;
    - increment `row_idx`.
- Win check at Enter: all five green bits of `scored_row` (bits 33, 26, 19, 12, 5) set. The block then sets `won` and enters DONE.
- Loss check at Enter: not a win and `row_idx` == MAX_ROWS−1. The block then sets `lost` and enters DONE, with `row_idx` = MAX_ROWS.
- In DONE, all key events are ignored. Only `new_game` or reset leaves DONE.
- `key_valid` with no qualifier and code 0 is a no-op.

## Timing

- All state updates on the rising edge of `clk`. Outputs are registered.
- `cur_row` and `cursor` reflect a keystroke one cycle after the `key_valid` strobe.
- `scored_row` is sampled on the Enter edge. The scorer is combinational from `cur_row`, so there is no added latency.
- `commit`, `won`/`lost`, the `row_idx` increment and the `board` update all become visible together, one cycle after Enter.
- Back-to-back strobes on consecutive cycles are each processed.
- Reset asserted mid-row discards the partial guess immediately, without waiting for a clock edge.

## Configuration

- `GUESS_BACKSPACE_EN` defined: Backspace behaves as described above.
- `GUESS_BACKSPACE_EN` undefined: `key_back` is ignored and logic is not built. Enter and letter behaviour are unchanged.

## Structure

- Shared package `wordle_pkg` holds:
  - tile width 7 and the bit offsets (YELLOW_BIT = 6, GREEN_BIT = 5, letter [4:0]);
  - WORD_LEN and MAX_ROWS defaults;
  - LETTER_BLANK = 0;
  - the TYPING/DONE state encoding.
- No sub-module. The scorer is instantiated alongside this block at the parent level, not inside it.

## Test plan

- **Type a row:** type C,R,A,N,E (codes 3,18,1,14,5) → `cur_row[32:28]` = 3, `cur_row[4:0]` = 5, `cursor` = 5. A sixth letter leaves `cur_row` unchanged.
- **Backspace:** type C,R then Backspace twice, then Backspace at empty → `cursor` goes 2→1→0→0 and `cur_row` = 0.
- **Short Enter:** press Enter at `cursor` = 4 → no `commit`, `row_idx` stays 0.
- **Winning row:** feed a full row with all greens set on `scored_row` → `commit` pulses once, `board[34:0]` = `scored_row`, `won` = 1. Later keys are ignored.
- **Loss:** make six non-winning submits → `lost` = 1 after the sixth, `row_idx` = 6, `won` = 0.
- **Reset and restart:**
  - assert `rst_n` low asynchronously mid-row → all outputs read 0 before the next edge;
  - `new_game` in the same cycle as Enter → board cleared, no `commit`.
